// File: rtl/seaquest_step_ctrl.sv
// Episode/step controller wrapped around the Seaquest Compute_Single stage.
// Owns the game state register, runs one agent action per step through the
// compute stage, and presents obs/reward/done/truncation/episode-return.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for an action, or an env reset when i_env_rst is high
// S_WAIT    | compute enabled with stable sta/act, waiting for its valid
// S_PRESENT | result held on the outputs until the agent takes it
module seaquest_step_ctrl #(
    parameter int STA_WL    = 736,
    parameter int ACT_WL    = 3,
    parameter int OBS_WL    = 736,
    parameter int RWD_WL    = 32,
    parameter int STEP_WL   = 16,
    parameter int MAX_STEPS = 27000,
    parameter int TIMEOUT   = 64
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [STA_WL-1:0]  i_init_sta,
    input  logic               i_env_rst,
    input  logic               i_act_valid,
    output logic               o_act_ready,
    input  logic [ACT_WL-1:0]  i_act,
    output logic               o_cmp_ena,
    output logic [STA_WL-1:0]  o_cmp_sta,
    output logic [ACT_WL-1:0]  o_cmp_act,
    input  logic [STA_WL-1:0]  i_cmp_sta,
    input  logic [OBS_WL-1:0]  i_cmp_obs,
    input  logic [RWD_WL-1:0]  i_cmp_rwd,
    input  logic               i_cmp_done,
    input  logic               i_cmp_valid,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [OBS_WL-1:0]  o_obs,
    output logic [RWD_WL-1:0]  o_rwd,
    output logic               o_done,
    output logic               o_trunc,
    output logic [RWD_WL-1:0]  o_ep_return,
    output logic [STEP_WL-1:0] o_step_cnt,
    output logic               o_err
);

    // Wide enough to hold TIMEOUT-1; the counter never needs to reach TIMEOUT.
    localparam int WAIT_WL = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_WL-1:0] WAIT_LAST = WAIT_WL'(TIMEOUT - 1);
    localparam logic [STEP_WL-1:0] STEP_LIMIT = STEP_WL'(MAX_STEPS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } fsm_t;

    fsm_t fsm, fsm_next;

    logic [STA_WL-1:0]  sta;
    logic [ACT_WL-1:0]  act;
    logic [WAIT_WL-1:0] wait_cnt;
    logic [OBS_WL-1:0]  obs;
    logic [RWD_WL-1:0]  rwd;
    logic               done;
    logic               trunc;
    logic [RWD_WL-1:0]  ep_return;
    logic [STEP_WL-1:0] step_cnt;
    logic [STEP_WL-1:0] step_next;
    logic               err;

    logic act_ready;
    logic accept;
    logic capture;
    logic timeout;
    logic release_res;
    logic new_episode;

    assign step_next   = step_cnt + 1'b1;
    assign new_episode = ((fsm == S_IDLE) && i_env_rst) || (release_res && (done || trunc));

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_next;
        end
    end

    // Next-state and step event decode.
    always_comb begin
        fsm_next    = fsm;
        act_ready   = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout     = 1'b0;
        release_res = 1'b0;
        case (fsm)
            S_IDLE: begin
                // An env reset takes the whole cycle; a concurrent action is refused.
                act_ready = !i_env_rst;
                if (!i_env_rst && i_act_valid) begin
                    accept   = 1'b1;
                    fsm_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_cmp_valid) begin
                    capture  = 1'b1;
                    fsm_next = S_PRESENT;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout  = 1'b1;
                    fsm_next = S_IDLE;
                end
            end
            S_PRESENT: begin
                if (i_res_ready) begin
                    release_res = 1'b1;
                    fsm_next    = S_IDLE;
                end
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    // Game state, latched action, step results and episode counters.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sta       <= i_init_sta;
            act       <= '0;
            wait_cnt  <= '0;
            obs       <= '0;
            rwd       <= '0;
            done      <= 1'b0;
            trunc     <= 1'b0;
            ep_return <= '0;
            step_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                act      <= i_act;
                wait_cnt <= '0;
            end else if (fsm == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (capture) begin
                sta       <= i_cmp_sta;
                obs       <= i_cmp_obs;
                rwd       <= i_cmp_rwd;
                done      <= i_cmp_done;
                ep_return <= ep_return + i_cmp_rwd;
                step_cnt  <= step_next;
                trunc     <= (step_next == STEP_LIMIT) && !i_cmp_done;
            end
            if (timeout) begin
                err <= 1'b1;
            end
            // Never coincides with capture: env reset is IDLE-only, release is PRESENT-only.
            if (new_episode) begin
                sta       <= i_init_sta;
                ep_return <= '0;
                step_cnt  <= '0;
            end
        end
    end

    assign o_act_ready = act_ready && i_rstn;
    assign o_cmp_ena   = (fsm == S_WAIT);
    assign o_res_valid = (fsm == S_PRESENT);
    assign o_cmp_sta   = sta;
    assign o_cmp_act   = act;
    assign o_obs       = obs;
    assign o_rwd       = rwd;
    assign o_done      = done;
    assign o_trunc     = trunc;
    assign o_ep_return = ep_return;
    assign o_step_cnt  = step_cnt;
    assign o_err       = err;

endmodule

// File: doc/seaquest_step_ctrl.md
Name: seaquest_step_ctrl

Overview:
- Episode/step controller sitting directly around the Seaquest Compute_Single stage.
- Holds the authoritative game state register and accepts one agent action per step over a valid/ready handshake.
- Drives Compute_Single (sta/act/ena), captures its o_sta/o_obs/o_rwd/o_done on o_valid, and presents obs/reward/done/truncation/episode-return to the agent.
- On episode end, reloads the initial state so the next step starts a fresh episode.

Parameters:
- STA_WL, 736: state width; must match Compute_Single.
- ACT_WL, 3: action width.
- OBS_WL, 736: observation width.
- RWD_WL, 32: reward and episode-return width.
- STEP_WL, 16: step counter width.
- MAX_STEPS, 27000: truncation step limit (1..2^STEP_WL-1).
- TIMEOUT, 64: max cycles to wait for compute valid.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_init_sta  in  STA_WL  initial episode state; held constant by the integrator
- i_env_rst  in  1  request new episode; honoured in IDLE only
- i_act_valid  in  1  agent action valid
- o_act_ready  out  1  controller accepts action
- i_act  in  ACT_WL  agent action
- o_cmp_ena  out  1  to Compute_Single i_ena
- o_cmp_sta  out  STA_WL  to Compute_Single i_sta
- o_cmp_act  out  ACT_WL  to Compute_Single i_act
- i_cmp_sta  in  STA_WL  from Compute_Single o_sta
- i_cmp_obs  in  OBS_WL  from Compute_Single o_obs
- i_cmp_rwd  in  RWD_WL  from Compute_Single o_rwd
- i_cmp_done  in  1  from Compute_Single o_done
- i_cmp_valid  in  1  from Compute_Single o_valid
- o_res_valid  out  1  step result valid
- i_res_ready  in  1  agent accepts result
- o_obs  out  OBS_WL  captured observation
- o_rwd  out  RWD_WL  captured step reward
- o_done  out  1  terminal step
- o_trunc  out  1  step limit reached and not terminal
- o_ep_return  out  RWD_WL  cumulative episode reward including this step
- o_step_cnt  out  STEP_WL  steps taken in episode including this step
- o_err  out  1  sticky compute-timeout flag

Behaviour:
- Reset (i_rstn=0 at posedge):
  - state reg <= i_init_sta; FSM <= IDLE.
  - All outputs 0: o_obs, o_rwd, o_ep_return, o_step_cnt, o_done, o_trunc, o_err, o_res_valid, o_cmp_ena.
  - o_act_ready = 0 while i_rstn=0.
  - Reset mid-operation aborts the step; no result is presented.
- o_cmp_sta always equals the state reg. o_cmp_act is the latched action.
- FSM states:
  - IDLE:
    - o_act_ready = !i_env_rst (combinational).
    - If i_env_rst=1: state reg <= i_init_sta, ep_return <= 0, step_cnt <= 0; stay in IDLE. Any simultaneous action is not accepted.
    - Else on i_act_valid & o_act_ready: latch i_act, go to WAIT.
  - WAIT:
    - o_cmp_ena = 1 (registered, asserted from the cycle after acceptance). o_cmp_sta and o_cmp_act are stable throughout.
    - Wait counter increments each cycle.
    - i_cmp_valid=1 sampled:
      - State reg <= i_cmp_sta; o_obs <= i_cmp_obs; o_rwd <= i_cmp_rwd; o_done <= i_cmp_done.
      - ep_return <= ep_return + i_cmp_rwd, mod 2^RWD_WL.
      - step_cnt <= step_cnt + 1.
      - o_trunc <= (step_cnt+1 == MAX_STEPS) & !i_cmp_done.
      - o_cmp_ena <= 0; go to PRESENT.
    - Counter reaches TIMEOUT without valid: o_err <= 1 (sticky until reset), o_cmp_ena <= 0. State reg and counters are unchanged; go to IDLE with no result.
    - i_cmp_valid while not in WAIT is ignored.
  - PRESENT:
    - o_res_valid = 1. All result outputs are held stable until i_res_ready.
    - o_act_ready = 0.
    - On i_res_ready: o_res_valid <= 0.
      - If o_done | o_trunc: state reg <= i_init_sta, ep_return <= 0, step_cnt <= 0.
      - Go to IDLE.
    - o_ep_return and o_step_cnt show pre-clear values while presented.
- Minimum step latency: acceptance -> o_cmp_ena (1 cycle) -> compute latency L -> o_res_valid 1 cycle after valid is sampled.
- Only one step is in flight; there is no pipelining or buffering beyond one result.

Test Plan:
- Basic step: reset, stub compute returns valid 5 cycles after ena with rwd=20, done=0; agent sends act=3'b011 -> o_cmp_act=3, o_cmp_ena high exactly 5 cycles, o_rwd=20, o_ep_return=20, o_step_cnt=1, o_done=0, o_trunc=0.
- Accumulation/wrap: 3 steps with rwd 0xFFFFFFF0, 0x10, 5 -> o_ep_return 0xFFFFFFF0, 0, 5; o_step_cnt 1, 2, 3.
- Terminal: step 2 returns done=1, rwd=7 -> o_done=1, o_ep_return=previous+7; after handshake o_cmp_sta equals i_init_sta and the next step reports o_step_cnt=1.
- Truncation: MAX_STEPS=4, done always 0 -> 4th result has o_trunc=1, o_step_cnt=4; 5th step reports o_step_cnt=1, o_ep_return equals its own reward.
- Backpressure/timeout: hold i_res_ready=0 for 3 cycles -> outputs stable, o_act_ready=0. Separately, stub never asserts valid with TIMEOUT=8 -> o_err=1 after 8 WAIT cycles, no o_res_valid, o_act_ready returns high.
- Reset/env_rst: drop i_rstn during WAIT -> next cycle all outputs 0, o_cmp_sta=i_init_sta. In IDLE, assert i_env_rst together with i_act_valid -> action not accepted, counters 0.
